// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and output saturation for the 2x polyphase
// interpolation engine.
package fir_pkg;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned COEF_W    = 24;
  localparam int unsigned TAPS      = 16;
  localparam int unsigned OUT_SHIFT = 22;
  localparam int unsigned ACC_W     = 52;
  localparam int unsigned PROD_W    = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } state_t;

  // Arithmetic shift followed by clamping to the signed DATA_W range.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> OUT_SHIFT;
    if (sh[ACC_W-1:DATA_W-1] == '0 || sh[ACC_W-1:DATA_W-1] == '1)
      return sh[DATA_W-1:0];
    else if (sh[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/fir_interp2_engine_if.sv
// Sample-in / sample-out handshakes plus the coefficient ROM read port.
interface fir_interp2_engine_if;
  import fir_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [4:0]        rom_addr;
  logic [COEF_W-1:0] rom_data;

  modport master (
    input  in_valid, in_data, out_ready, rom_data,
    output in_ready, out_valid, out_data, rom_addr
  );

  modport slave (
    output in_valid, in_data, out_ready, rom_data,
    input  in_ready, out_valid, out_data, rom_addr
  );

endinterface

// File: rtl/fir_hist_ring.sv
// 16-entry sample history ring; write advances the pointer, read is registered
// and indexed relative to the newest sample (tap 0 = newest).
module fir_hist_ring
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        tap,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [TAPS];
  logic [3:0]        wptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rd_data <= '0;
      for (int unsigned i = 0; i < TAPS; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        wptr              <= wptr + 4'd1;
        mem[wptr + 4'd1]  <= wr_data;
      end
      rd_data <= mem[wptr - tap];
    end
  end

endmodule

// File: rtl/fir_interp2_engine.sv
// Polyphase 2x interpolation MAC engine: one input sample yields a phase-0 and
// a phase-1 output, each a 16-tap MAC against an external registered ROM.
module fir_interp2_engine
  import fir_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  fir_interp2_engine_if.master bus
);

  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) <<< (OUT_SHIFT - 1);

  state_t                    state, state_nx;
  logic                      phase;
  logic [3:0]                k;
  logic                      drain;
  logic                      v1, v2;
  logic signed [DATA_W-1:0]  samp;
  logic signed [COEF_W-1:0]  coef;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc, prod_ext, acc_sum;
  logic                      accept;

  assign accept       = (state == IDLE) && bus.in_valid;
  assign bus.in_ready = (state == IDLE);
  assign bus.rom_addr = {phase, k};
  assign coef         = bus.rom_data;

  fir_hist_ring u_hist (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (bus.in_data),
    .tap     (k),
    .rd_data (samp)
  );

  // Sample and coefficient for tap k both land one cycle after k is issued;
  // v1/v2 track the product through the multiply and accumulate stages.
  assign prod_ext = v2 ? ACC_W'(prod) : '0;
  assign acc_sum  = acc + prod_ext;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = MAC;
      MAC:     if (k == 4'd15)    state_nx = DRAIN;
      DRAIN:   if (drain)         state_nx = OUT;
      OUT:     if (bus.out_ready) state_nx = phase ? IDLE : MAC;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= 1'b0;
      k             <= '0;
      drain         <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      prod          <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state <= state_nx;
      v1    <= (state == MAC);
      v2    <= v1;
      prod  <= PROD_W'(samp) * PROD_W'(coef);
      acc   <= acc_sum;
      case (state)
        IDLE: if (bus.in_valid) begin
          phase <= 1'b0;
          k     <= '0;
          acc   <= ROUND;
        end
        MAC: begin
          drain <= 1'b0;
          if (k != 4'd15) k <= k + 4'd1;
        end
        DRAIN: begin
          drain <= 1'b1;
          // Last product is still in flight, so saturate the bypassed sum.
          if (drain) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= saturate(acc_sum);
          end
        end
        OUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          if (!phase) begin
            phase <= 1'b1;
            k     <= '0;
            acc   <= ROUND;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp2_engine.sv
// Bench for fir_interp2_engine: impulse table, latency, backpressure,
// mid-operation reset and saturation, with a queue-based output scoreboard.
module tb_fir_interp2_engine;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rom_sat = 1'b0;

  fir_interp2_engine_if bus();

  fir_interp2_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic signed [23:0] rom_tbl [32] = '{
    24'h164B2D, 24'hF5BAE8, 24'h0A1234, 24'hFC0F11, 24'h03A5C2, 24'hFE7D40, 24'h00C3B9, 24'hFF8A21,
    24'h0041F0, 24'hFFD012, 24'h001A3C, 24'hFFF0A5, 24'h0008C7, 24'hFFFB12, 24'h000311, 24'hFFFF42,
    24'h35A6A3, 24'hF90C13, 24'h05E7A1, 24'hFD3B70, 24'h0198C4, 24'hFF1E05, 24'h007A33, 24'hFFC1D8,
    24'h0021F9, 24'hFFE6A4, 24'h000D57, 24'hFFF812, 24'h0003A9, 24'hFFFD66, 24'h00011B, 24'hFFFFC8
  };

  // Registered ROM: data follows the address by one clock.
  always @(posedge clk) bus.rom_data <= rom_sat ? 24'h7FFFFF : rom_tbl[bus.rom_addr];

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [23:0] exp_q [$];

  logic signed [23:0] m_hist [16];
  logic [3:0]         m_wptr;

  typedef struct {
    logic [23:0] din;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;
  vec_t tbl [17];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void model_update(input logic [23:0] d);
    m_wptr = m_wptr + 4'd1;
    m_hist[m_wptr] = d;
  endfunction

  function automatic logic [23:0] model_out(input int unsigned ph);
    longint acc = 64'sd2097152;
    for (int k = 0; k < 16; k++) begin
      longint s, c;
      s = longint'(m_hist[(int'(m_wptr) - k) & 15]);
      c = rom_sat ? 64'sd8388607 : longint'(rom_tbl[ph * 16 + k]);
      acc += s * c;
    end
    acc = acc >>> 22;
    if (acc > 64'sd8388607) return 24'h7FFFFF;
    if (acc < -64'sd8388608) return 24'h800000;
    return acc[23:0];
  endfunction

  function automatic void model_clear();
    foreach (m_hist[i]) m_hist[i] = '0;
    m_wptr = '0;
    exp_q.delete();
  endfunction

  // Scoreboard: every handshake pops one expected output.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %h with no output expected", bus.out_data);
      end else begin
        check("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [23:0] d, input bit use_model, input logic [23:0] e0, input logic [23:0] e1);
    int unsigned n = 0;
    model_update(d);
    if (use_model) begin
      exp_q.push_back(model_out(0));
      exp_q.push_back(model_out(1));
    end else begin
      exp_q.push_back(e0);
      exp_q.push_back(e1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [23:0] sv_data;
    logic [4:0]  sv_addr;
    int unsigned n;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] sv_data;
    logic [4:0]  sv_addr;
    int unsigned n;

    tbl[0] = '{24'h400000, rom_tbl[0], rom_tbl[16]};
    for (int k = 1; k < 16; k++) tbl[k] = '{24'h000000, rom_tbl[k], rom_tbl[16 + k]};
    tbl[16] = '{24'h000000, 24'h000000, 24'h000000};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Impulse response, including pointer wrap on the 17th sample.
    for (int i = 0; i < 17; i++) send(tbl[i].din, 1'b0, tbl[i].e0, tbl[i].e1);
    wait_drain();

    // Latency with out_ready held high.
    model_update(24'h123456);
    exp_q.push_back(model_out(0));
    exp_q.push_back(model_out(1));
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h123456;
    @(negedge clk);
    check("lat_in_ready_c0", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      check($sformatf("lat_out_valid_c%0d", t), bus.out_valid, (t == 19 || t == 38));
      check($sformatf("lat_in_ready_c%0d", t), bus.in_ready, (t >= 39));
    end
    wait_drain();

    // Backpressure on the phase-0 output with a pending input held.
    bus.out_ready = 1'b0;
    send(24'h2A0F31, 1'b1, '0, '0);
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h111111;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", bus.out_valid, 1);
    sv_data = bus.out_data;
    sv_addr = bus.rom_addr;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, sv_data);
      check("bp_rom_addr", bus.rom_addr, sv_addr);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", bus.out_valid, 1);
    for (int t = 1; t <= 19; t++) begin
      @(negedge clk);
      check($sformatf("bp_ph1_valid_h+%0d", t), bus.out_valid, (t == 19));
    end
    wait_drain();

    // Reset in the middle of a MAC sequence.
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h400000;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_data", bus.out_data, 0);
    send(24'h400000, 1'b0, 24'h164B2D, 24'h35A6A3);
    wait_drain();

    // Saturation with a full-scale coefficient ROM.
    do_reset();
    rom_sat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 15) send(24'h7FFFFF, 1'b1, '0, '0);
      else        send(24'h7FFFFF, 1'b0, 24'h7FFFFF, 24'h7FFFFF);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < 15) send(24'h800000, 1'b1, '0, '0);
      else        send(24'h800000, 1'b0, 24'h800000, 24'h800000);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
